// File: rtl/event_serializer_pkg.sv
// Shared record layout and FSM encodings for the event serializer.
package event_serializer_pkg;

  localparam int REC_W = 16;
  localparam int UID_W = 4;
  localparam int EVT_W = 2;
  localparam int TS_W  = 9;

  typedef enum logic {
    S_IDLE,
    S_SCAN
  } scan_state_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_HI,
    T_LO
  } tx_state_t;

  // Record = {unit_id, event, spike, timestamp}
  function automatic logic [REC_W-1:0] make_record(input logic [UID_W-1:0] uid,
                                                   input logic [EVT_W-1:0] evt,
                                                   input logic             spk,
                                                   input logic [TS_W-1:0]  ts);
    return {uid, evt, spk, ts};
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous record FIFO; pushes while full and pops while empty are ignored.
module event_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/event_serializer.sv
// Snapshots per-unit spike/event flags per frame, packs active units into
// timestamped 16-bit records and streams them out MSB byte first.
//
// state  | meaning
// S_IDLE | waiting for sample_valid
// S_SCAN | walking the snapshot, one unit per cycle
// T_IDLE | no record held, nothing presented
// T_HI   | presenting hold[15:8]
// T_LO   | presenting hold[7:0]
module event_serializer
  import event_serializer_pkg::*;
#(
  parameter int NUM_UNITS  = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_WIDTH   = 9
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_UNITS-1:0]          spike_detection_array,
  input  logic [2*NUM_UNITS-1:0]        event_out_array,
  input  logic                          sample_valid,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_drop
);

  localparam int IW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  scan_state_t         scan_state, scan_next;
  tx_state_t           tx_state, tx_next;
  logic [TS_WIDTH-1:0] ts, snap_ts;
  logic                snap_spk [NUM_UNITS];
  logic [EVT_W-1:0]    snap_evt [NUM_UNITS];
  logic [IW-1:0]       idx;
  logic                scan_last, unit_active, push_req;
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [REC_W-1:0]    rec, fifo_dout, hold;

  assign scan_last   = (idx == IW'(NUM_UNITS - 1));
  assign unit_active = snap_spk[idx] | (snap_evt[idx] != '0);
  assign rec         = make_record(UID_W'(idx), snap_evt[idx], snap_spk[idx], snap_ts);
  assign push_req    = (scan_state == S_SCAN) && unit_active;
  assign fifo_push   = push_req && !fifo_full;

  always_ff @(posedge clk) begin
    if (rst) scan_state <= S_IDLE;
    else     scan_state <= scan_next;
  end

  always_comb begin
    scan_next = scan_state;
    case (scan_state)
      S_IDLE:  if (sample_valid) scan_next = S_SCAN;
      S_SCAN:  if (scan_last) scan_next = S_IDLE;
      default: scan_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts         <= '0;
      snap_ts    <= '0;
      idx        <= '0;
      overflow   <= 1'b0;
      frame_drop <= 1'b0;
      for (int i = 0; i < NUM_UNITS; i++) begin
        snap_spk[i] <= 1'b0;
        snap_evt[i] <= '0;
      end
    end else begin
      if (sample_valid) ts <= ts + TS_WIDTH'(1);
      if (scan_state == S_IDLE && sample_valid) begin
        snap_ts <= ts;
        idx     <= '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
          snap_spk[i] <= spike_detection_array[i];
          snap_evt[i] <= event_out_array[2*i +: 2];
        end
      end else if (scan_state == S_SCAN) begin
        idx <= idx + IW'(1);
      end
      if (sample_valid && scan_state == S_SCAN) frame_drop <= 1'b1;
      if (push_req && fifo_full) overflow <= 1'b1;
    end
  end

  event_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (rec),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Popping from T_LO refills hold in the same cycle the low byte is taken.
  assign fifo_pop = !fifo_empty &&
                    ((tx_state == T_IDLE) || (tx_state == T_LO && out_ready));

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= T_IDLE;
      hold     <= '0;
    end else begin
      tx_state <= tx_next;
      if (fifo_pop) hold <= fifo_dout;
    end
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      T_IDLE:  if (!fifo_empty) tx_next = T_HI;
      T_HI:    if (out_ready) tx_next = T_LO;
      T_LO:    if (out_ready) tx_next = fifo_empty ? T_IDLE : T_HI;
      default: tx_next = T_IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'h00;
    case (tx_state)
      T_HI: begin
        out_valid = 1'b1;
        out_data  = hold[15:8];
      end
      T_LO: begin
        out_valid = 1'b1;
        out_data  = hold[7:0];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_event_serializer.sv
// Scoreboard bench: expected records are queued as frames are driven and
// checked as byte pairs leave the output handshake.
module tb_event_serializer;

  localparam int NU    = 2;
  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NU-1:0]   spk;
  logic [2*NU-1:0] evt;
  logic            sv;
  logic            ready;
  logic [7:0]      out_data;
  logic            out_valid;
  logic [3:0]      fifo_level;
  logic            overflow;
  logic            frame_drop;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_q[$];
  logic [8:0]  m_ts;
  logic [7:0]  hi_byte;
  bit          have_hi = 0;

  event_serializer #(.NUM_UNITS(NU), .FIFO_DEPTH(DEPTH), .TS_WIDTH(9)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .spike_detection_array (spk),
    .event_out_array       (evt),
    .sample_valid          (sv),
    .out_data              (out_data),
    .out_valid             (out_valid),
    .out_ready             (ready),
    .fifo_level            (fifo_level),
    .overflow              (overflow),
    .frame_drop            (frame_drop)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Byte pairs accepted on the handshake are rebuilt into records.
  always @(negedge clk) begin
    logic [15:0] got, exp;
    if (rst) begin
      have_hi = 0;
    end else if (out_valid && ready) begin
      if (!have_hi) begin
        hi_byte = out_data;
        have_hi = 1;
      end else begin
        have_hi = 0;
        got = {hi_byte, out_data};
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL record: got %h, expected no record", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            fails++;
            $display("FAIL record: got %h, expected %h", got, exp);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    m_ts = '0;
  endtask

  // One-cycle strobe; a frame that will be dropped is driven with expect_rec=0.
  task automatic drive_frame(input logic [NU-1:0] s, input logic [2*NU-1:0] e,
                             input bit expect_rec);
    sv  = 1'b1;
    spk = s;
    evt = e;
    if (expect_rec)
      for (int u = 0; u < NU; u++)
        if (s[u] || e[2*u +: 2] != 2'b00)
          exp_q.push_back({4'(u), e[2*u +: 2], s[u], m_ts});
    m_ts = m_ts + 9'd1;
    tick();
    sv  = 1'b0;
    spk = '0;
    evt = '0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      tick();
      n++;
    end
    tests++;
    if (n >= 300) begin
      fails++;
      $display("FAIL drain: %0d records still pending after %0d cycles, expected 0",
               exp_q.size(), n);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    tests += 5;
    if (out_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h, expected 00", out_data); end
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, expected 0", out_valid); end
    if (fifo_level !== 4'd0) begin fails++; $display("FAIL reset_level: got %0d, expected 0", fifo_level); end
    if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b, expected 0", overflow); end
    if (frame_drop !== 1'b0) begin fails++; $display("FAIL reset_frame_drop: got %b, expected 0", frame_drop); end
  endtask

  task automatic test_latency();
    int n = 1;
    ready = 1'b1;
    drive_frame(2'b01, 4'b0000, 1);
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    tests++;
    if (n !== 3) begin
      fails++;
      $display("FAIL latency: first out_valid after %0d cycles, expected 3", n);
    end
    wait_drain();
  endtask

  task automatic test_second_frame();
    apply_reset();
    ready = 1'b1;
    drive_frame(2'b01, 4'b0000, 1);
    repeat (4) tick();
    drive_frame(2'b10, 4'b1100, 1);
    wait_drain();
  endtask

  task automatic test_backpressure();
    int n = 0;
    apply_reset();
    ready = 1'b0;
    drive_frame(2'b01, 4'b0000, 1);
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    for (int i = 0; i < 20; i++) begin
      tests++;
      if (out_valid !== 1'b1 || out_data !== 8'h02) begin
        fails++;
        $display("FAIL stall_hold: cycle %0d got valid=%b data=%h, expected valid=1 data=02",
                 i, out_valid, out_data);
      end
      tick();
    end
    ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_overflow();
    apply_reset();
    ready = 1'b0;
    for (int f = 0; f < 5; f++) begin
      drive_frame(2'b11, 4'b0000, 1);
      repeat (3) tick();
    end
    // The first record sits in the output holding register, so the FIFO plus
    // hold keep nine records; only the tenth (unit 1, ts 4) is lost.
    void'(exp_q.pop_back());
    repeat (2) tick();
    tests += 2;
    if (fifo_level !== 4'd8) begin fails++; $display("FAIL ovf_level: got %0d, expected 8", fifo_level); end
    if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b, expected 1", overflow); end
    ready = 1'b1;
    wait_drain();
    tests++;
    if (fifo_level !== 4'd0) begin fails++; $display("FAIL ovf_drained_level: got %0d, expected 0", fifo_level); end
  endtask

  task automatic test_back_to_back_frames();
    apply_reset();
    ready = 1'b1;
    drive_frame(2'b01, 4'b0000, 1);
    drive_frame(2'b01, 4'b0000, 0);
    tick();
    tests++;
    if (frame_drop !== 1'b1) begin fails++; $display("FAIL frame_drop: got %b, expected 1", frame_drop); end
    repeat (3) tick();
    drive_frame(2'b01, 4'b0000, 1);
    wait_drain();
  endtask

  task automatic test_reset_mid_tx();
    apply_reset();
    ready = 1'b0;
    drive_frame(2'b11, 4'b0000, 1);
    drive_frame(2'b11, 4'b0000, 0);
    repeat (4) tick();
    drive_frame(2'b11, 4'b0000, 1);
    repeat (4) tick();
    tests++;
    if (fifo_level !== 4'd3) begin fails++; $display("FAIL midtx_level: got %0d, expected 3", fifo_level); end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_data !== 8'h00) begin
      fails++;
      $display("FAIL midtx_lo: got valid=%b data=%h, expected valid=1 data=00", out_valid, out_data);
    end
    rst = 1'b1;
    tick();
    tests += 4;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b, expected 0", out_valid); end
    if (fifo_level !== 4'd0) begin fails++; $display("FAIL rst_level: got %0d, expected 0", fifo_level); end
    if (overflow !== 1'b0) begin fails++; $display("FAIL rst_overflow: got %b, expected 0", overflow); end
    if (frame_drop !== 1'b0) begin fails++; $display("FAIL rst_frame_drop: got %b, expected 0", frame_drop); end
    rst = 1'b0;
    exp_q.delete();
    m_ts = '0;
    ready = 1'b1;
    drive_frame(2'b01, 4'b0000, 1);
    wait_drain();
  endtask

  initial begin
    rst   = 1'b1;
    sv    = 1'b0;
    spk   = '0;
    evt   = '0;
    ready = 1'b0;
    m_ts  = '0;
    test_reset();
    test_latency();
    test_second_frame();
    test_backpressure();
    test_overflow();
    test_back_to_back_frames();
    test_reset_mid_tx();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
